// File: rtl/sfifo_pkt_if.sv
// Write/read bundle of the packet FIFO.
// master = producer/consumer side, slave = FIFO.
interface sfifo_pkt_if #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4
);
   logic              i_flush;
   logic              i_wr;
   logic [BW-1:0]     i_data;
   logic              i_commit;
   logic              i_abort;
   logic              o_full;
   logic [LGFLEN:0]   o_pending;
   logic              o_overflow;
   logic [LGFLEN:0]   i_afull_thresh;
   logic              o_afull;
   logic              i_rd;
   logic [BW-1:0]     o_data;
   logic              o_empty;
   logic [LGFLEN:0]   o_fill;
   logic [LGFLEN:0]   i_aempty_thresh;
   logic              o_aempty;
   logic              o_underflow;

   modport master (
      output i_flush, i_wr, i_data, i_commit, i_abort,
      output i_afull_thresh, i_rd, i_aempty_thresh,
      input  o_full, o_pending, o_overflow, o_afull,
      input  o_data, o_empty, o_fill, o_aempty, o_underflow
   );

   modport slave (
      input  i_flush, i_wr, i_data, i_commit, i_abort,
      input  i_afull_thresh, i_rd, i_aempty_thresh,
      output o_full, o_pending, o_overflow, o_afull,
      output o_data, o_empty, o_fill, o_aempty, o_underflow
   );
endinterface

// File: rtl/sfifo_pkt.sv
// First-word-fall-through FIFO with packet commit/abort,
// thresholds, flush and overflow/underflow pulses.
module sfifo_pkt #(
   parameter int BW             = 8,
   parameter int LGFLEN         = 4,
   parameter bit OPT_PACKET     = 1'b1,
   parameter bit OPT_ASYNC_READ = 1'b1
) (
   input logic         i_clk,
   input logic         i_reset_n,
   sfifo_pkt_if.slave  bus
);
   localparam int FLEN = 1 << LGFLEN;
   localparam logic [LGFLEN:0] FLEN_P = (LGFLEN+1)'(FLEN);

   typedef logic [LGFLEN:0] ptr_t;

   ptr_t wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
   ptr_t fill_q, fill_d, pend_q, pend_d, total_d;
   logic full_q, full_d, empty_q, empty_d;
   logic afull_q, afull_d, aempty_q, aempty_d;
   logic ovf_q, ovf_d, udf_q, udf_d;
   logic w_wr, w_rd, mem_we;

   logic [BW-1:0] mem [FLEN];

   always_comb begin
      w_wr   = bus.i_wr && !full_q;
      w_rd   = bus.i_rd && !empty_q;
      mem_we = w_wr && !bus.i_flush;
      wr_d   = wr_q + ptr_t'(w_wr);
      cm_d   = cm_q;
      rd_d   = rd_q + ptr_t'(w_rd);
      if (bus.i_flush) begin
         wr_d = '0;
         cm_d = '0;
         rd_d = '0;
      end else if (OPT_PACKET && bus.i_abort) begin
         wr_d = cm_q;
      end else if (!OPT_PACKET || bus.i_commit) begin
         cm_d = wr_d;
      end
      fill_d   = cm_d - rd_d;
      pend_d   = wr_d - cm_d;
      total_d  = wr_d - rd_d;
      full_d   = (total_d == FLEN_P);
      empty_d  = (fill_d == '0);
      afull_d  = (total_d >= bus.i_afull_thresh);
      aempty_d = (fill_d <= bus.i_aempty_thresh);
      ovf_d    = bus.i_wr && full_q;
      udf_d    = bus.i_rd && empty_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_q     <= '0;
         cm_q     <= '0;
         rd_q     <= '0;
         fill_q   <= '0;
         pend_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         cm_q     <= cm_d;
         rd_q     <= rd_d;
         fill_q   <= fill_d;
         pend_q   <= pend_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[wr_q[LGFLEN-1:0]] <= bus.i_data;
   end

   generate
      if (OPT_ASYNC_READ) begin : g_async
         assign bus.o_data = mem[rd_q[LGFLEN-1:0]];
      end else begin : g_sync
         logic [BW-1:0] data_q, data_d;
         // Head slot written this cycle: take the write data directly.
         always_comb begin
            data_d = mem[rd_d[LGFLEN-1:0]];
            if (mem_we && wr_q[LGFLEN-1:0] == rd_d[LGFLEN-1:0])
               data_d = bus.i_data;
         end
         always_ff @(posedge i_clk) begin
            data_q <= data_d;
         end
         assign bus.o_data = data_q;
      end
   endgenerate

   assign bus.o_full      = full_q;
   assign bus.o_empty     = empty_q;
   assign bus.o_fill      = fill_q;
   assign bus.o_pending   = pend_q;
   assign bus.o_afull     = afull_q;
   assign bus.o_aempty    = aempty_q;
   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = udf_q;
endmodule

// File: tb/tb_sfifo_pkt.sv
// Directed bench: non-packet FIFO plus packet FIFOs with
// async and registered read, all driven in lockstep.
module tb_sfifo_pkt;
   localparam int BW = 8;
   localparam int LG = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sfifo_pkt_if #(.BW(BW), .LGFLEN(LG)) b0 ();
   sfifo_pkt_if #(.BW(BW), .LGFLEN(LG)) ba ();
   sfifo_pkt_if #(.BW(BW), .LGFLEN(LG)) bs ();

   sfifo_pkt #(
      .BW(BW), .LGFLEN(LG),
      .OPT_PACKET(1'b0), .OPT_ASYNC_READ(1'b1)
   ) u0 (.i_clk(clk), .i_reset_n(rst_n), .bus(b0));

   sfifo_pkt #(
      .BW(BW), .LGFLEN(LG),
      .OPT_PACKET(1'b1), .OPT_ASYNC_READ(1'b1)
   ) ua (.i_clk(clk), .i_reset_n(rst_n), .bus(ba));

   sfifo_pkt #(
      .BW(BW), .LGFLEN(LG),
      .OPT_PACKET(1'b1), .OPT_ASYNC_READ(1'b0)
   ) us (.i_clk(clk), .i_reset_n(rst_n), .bus(bs));

   typedef struct {
      bit       wr;
      bit [7:0] d;
      bit       cm;
      bit       ab;
      bit       rd;
      int       fill;
      int       pend;
      bit       empty;
      int       dat;
   } vec_t;

   vec_t vt[22];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk2(string nm, logic [31:0] a, logic [31:0] s,
                       logic [31:0] e);
      chk({"async_", nm}, a, e);
      chk({"sync_", nm}, s, e);
   endtask

   task automatic chk3(string nm, logic [31:0] z, logic [31:0] a,
                       logic [31:0] s, logic [31:0] e);
      chk({"nopkt_", nm}, z, e);
      chk2(nm, a, s, e);
   endtask

   task automatic thresh(int af, int ae);
      b0.i_afull_thresh  = 5'(af);
      ba.i_afull_thresh  = 5'(af);
      bs.i_afull_thresh  = 5'(af);
      b0.i_aempty_thresh = 5'(ae);
      ba.i_aempty_thresh = 5'(ae);
      bs.i_aempty_thresh = 5'(ae);
   endtask

   task automatic drive(bit wr, bit [7:0] d, bit cm, bit ab,
                        bit rd, bit fl);
      b0.i_wr = wr; ba.i_wr = wr; bs.i_wr = wr;
      b0.i_data = d; ba.i_data = d; bs.i_data = d;
      b0.i_commit = 1'b0; ba.i_commit = cm; bs.i_commit = cm;
      b0.i_abort = 1'b0; ba.i_abort = ab; bs.i_abort = ab;
      b0.i_rd = rd; ba.i_rd = rd; bs.i_rd = rd;
      b0.i_flush = fl; ba.i_flush = fl; bs.i_flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic chk_reset(string nm);
      chk3({nm, "_empty"}, b0.o_empty, ba.o_empty, bs.o_empty, 1);
      chk3({nm, "_full"}, b0.o_full, ba.o_full, bs.o_full, 0);
      chk3({nm, "_fill"}, b0.o_fill, ba.o_fill, bs.o_fill, 0);
      chk3({nm, "_pend"}, b0.o_pending, ba.o_pending,
           bs.o_pending, 0);
      chk3({nm, "_afull"}, b0.o_afull, ba.o_afull, bs.o_afull, 0);
      chk3({nm, "_aempty"}, b0.o_aempty, ba.o_aempty,
           bs.o_aempty, 1);
      chk3({nm, "_ovf"}, b0.o_overflow, ba.o_overflow,
           bs.o_overflow, 0);
      chk3({nm, "_udf"}, b0.o_underflow, ba.o_underflow,
           bs.o_underflow, 0);
   endtask

   initial begin
      //        wr d     cm ab rd fill pend empty dat
      vt[0]  = '{1, 8'h11, 0, 0, 0, 0, 1, 1, -1};
      vt[1]  = '{1, 8'h22, 0, 0, 0, 0, 2, 1, -1};
      vt[2]  = '{1, 8'h33, 0, 0, 0, 0, 3, 1, -1};
      vt[3]  = '{0, 8'h00, 1, 0, 0, 3, 0, 0, 'h11};
      vt[4]  = '{1, 8'h44, 0, 0, 0, 3, 1, 0, 'h11};
      vt[5]  = '{1, 8'h55, 0, 0, 0, 3, 2, 0, 'h11};
      vt[6]  = '{1, 8'h66, 0, 1, 0, 3, 0, 0, 'h11};
      vt[7]  = '{1, 8'h77, 1, 0, 0, 4, 0, 0, 'h11};
      vt[8]  = '{0, 8'h00, 0, 0, 1, 3, 0, 0, 'h22};
      vt[9]  = '{0, 8'h00, 0, 0, 1, 2, 0, 0, 'h33};
      vt[10] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 'h77};
      vt[11] = '{0, 8'h00, 0, 0, 1, 0, 0, 1, -1};
      vt[12] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, -1};
      vt[13] = '{1, 8'hCC, 1, 0, 0, 1, 0, 0, 'hCC};
      vt[14] = '{1, 8'h88, 0, 0, 1, 0, 1, 1, -1};
      vt[15] = '{1, 8'h99, 1, 0, 0, 2, 0, 0, 'h88};
      vt[16] = '{1, 8'hAA, 0, 1, 1, 1, 0, 0, 'h99};
      vt[17] = '{1, 8'hBB, 1, 1, 0, 1, 0, 0, 'h99};
      vt[18] = '{0, 8'h00, 0, 0, 1, 0, 0, 1, -1};
      vt[19] = '{1, 8'hD1, 1, 0, 0, 1, 0, 0, 'hD1};
      vt[20] = '{1, 8'hD2, 1, 0, 1, 1, 0, 0, 'hD2};
      vt[21] = '{0, 8'h00, 0, 0, 1, 0, 0, 1, -1};

      thresh(12, 2);
      rst_n = 1'b0;
      idle();
      idle();
      rst_n = 1'b1;
      chk_reset("rst");

      // 1: fill to full, overflow, drain, underflow
      for (int i = 0; i < 16; i++) drive(1, 8'(i + 1), 1, 0, 0, 0);
      chk3("t1_full", b0.o_full, ba.o_full, bs.o_full, 1);
      chk3("t1_fill", b0.o_fill, ba.o_fill, bs.o_fill, 16);
      drive(1, 8'hAA, 1, 0, 0, 0);
      chk3("t1_ovf", b0.o_overflow, ba.o_overflow,
           bs.o_overflow, 1);
      chk3("t1_fill_ovf", b0.o_fill, ba.o_fill, bs.o_fill, 16);
      idle();
      chk3("t1_ovf_clr", b0.o_overflow, ba.o_overflow,
           bs.o_overflow, 0);
      for (int i = 0; i < 16; i++) begin
         chk3("t1_data", b0.o_data, ba.o_data, bs.o_data, i + 1);
         drive(0, 8'h00, 0, 0, 1, 0);
      end
      chk3("t1_empty", b0.o_empty, ba.o_empty, bs.o_empty, 1);
      drive(0, 8'h00, 0, 0, 1, 0);
      chk3("t1_udf", b0.o_underflow, ba.o_underflow,
           bs.o_underflow, 1);
      idle();
      chk3("t1_udf_clr", b0.o_underflow, ba.o_underflow,
           bs.o_underflow, 0);

      // 2/3: commit/abort table
      for (int i = 0; i < 22; i++) begin
         drive(vt[i].wr, vt[i].d, vt[i].cm, vt[i].ab, vt[i].rd, 0);
         chk2($sformatf("v%0d_fill", i), ba.o_fill, bs.o_fill,
              vt[i].fill);
         chk2($sformatf("v%0d_pend", i), ba.o_pending,
              bs.o_pending, vt[i].pend);
         chk2($sformatf("v%0d_empty", i), ba.o_empty, bs.o_empty,
              32'(vt[i].empty));
         if (vt[i].dat >= 0)
            chk2($sformatf("v%0d_data", i), ba.o_data, bs.o_data,
                 vt[i].dat);
         if (i == 2) chk("nopkt_no_commit_fill", b0.o_fill, 3);
      end
      drive(0, 8'h00, 0, 0, 0, 1);
      chk3("t3_flush_fill", b0.o_fill, ba.o_fill, bs.o_fill, 0);
      chk3("t3_flush_empty", b0.o_empty, ba.o_empty, bs.o_empty, 1);

      // 4: thresholds
      for (int k = 1; k <= 12; k++) begin
         drive(1, 8'(k), 1, 0, 0, 0);
         chk3($sformatf("t4_afull%0d", k), b0.o_afull, ba.o_afull,
              bs.o_afull, 32'(k >= 12));
         chk3($sformatf("t4_aempty%0d", k), b0.o_aempty,
              ba.o_aempty, bs.o_aempty, 32'(k <= 2));
      end
      drive(0, 8'h00, 0, 0, 1, 0);
      chk3("t4_afull11", b0.o_afull, ba.o_afull, bs.o_afull, 0);
      drive(1, 8'h0D, 1, 0, 0, 0);
      chk3("t4_afull12", b0.o_afull, ba.o_afull, bs.o_afull, 1);
      drive(1, 8'h0E, 1, 0, 1, 0);
      chk3("t4_rw_fill", b0.o_fill, ba.o_fill, bs.o_fill, 12);
      chk3("t4_rw_afull", b0.o_afull, ba.o_afull, bs.o_afull, 1);
      for (int k = 11; k >= 2; k--) begin
         drive(0, 8'h00, 0, 0, 1, 0);
         chk3($sformatf("t4_dfill%0d", k), b0.o_fill, ba.o_fill,
              bs.o_fill, k);
         chk3($sformatf("t4_daempty%0d", k), b0.o_aempty,
              ba.o_aempty, bs.o_aempty, 32'(k <= 2));
      end
      thresh(12, 1);
      idle();
      chk3("t4_th1", b0.o_aempty, ba.o_aempty, bs.o_aempty, 0);
      thresh(12, 2);
      idle();
      chk3("t4_th2", b0.o_aempty, ba.o_aempty, bs.o_aempty, 1);
      drive(0, 8'h00, 0, 0, 0, 1);

      // 5: streaming wrap at constant fill
      for (int i = 0; i < 5; i++) drive(1, 8'(i), 1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         chk3($sformatf("t5_data%0d", i), b0.o_data, ba.o_data,
              bs.o_data, i);
         drive(1, 8'(i + 5), 1, 0, 1, 0);
         chk3($sformatf("t5_fill%0d", i), b0.o_fill, ba.o_fill,
              bs.o_fill, 5);
      end
      chk3("t5_data_end", b0.o_data, ba.o_data, bs.o_data, 40);
      drive(0, 8'h00, 0, 0, 0, 1);

      // 6: flush and reset mid-packet
      for (int i = 0; i < 9; i++) drive(1, 8'(8'h30 + i), 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h40 + i), 0, 0, 0, 0);
      chk2("t6_fill", ba.o_fill, bs.o_fill, 9);
      chk2("t6_pend", ba.o_pending, bs.o_pending, 3);
      chk("nopkt_t6_fill", b0.o_fill, 12);
      drive(1, 8'h55, 0, 0, 0, 1);
      chk3("t6_fl_fill", b0.o_fill, ba.o_fill, bs.o_fill, 0);
      chk3("t6_fl_pend", b0.o_pending, ba.o_pending,
           bs.o_pending, 0);
      chk3("t6_fl_empty", b0.o_empty, ba.o_empty, bs.o_empty, 1);
      chk3("t6_fl_full", b0.o_full, ba.o_full, bs.o_full, 0);
      drive(1, 8'h61, 0, 0, 0, 0);
      drive(1, 8'h62, 0, 0, 0, 0);
      chk2("t6_pend2", ba.o_pending, bs.o_pending, 2);
      rst_n = 1'b0;
      drive(1, 8'h66, 1, 0, 0, 0);
      rst_n = 1'b1;
      chk_reset("t6_rst");
      idle();
      chk3("t6_post_fill", b0.o_fill, ba.o_fill, bs.o_fill, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sfifo_pkt.md
Name: sfifo_pkt

Overview:
Synchronous first-word-fall-through data FIFO, the parametrised successor of the team's basic synchronous FIFO. Adds:
- Packet mode: write-side commit/abort, so the reader sees only committed words.
- Programmable almost-full and almost-empty thresholds.
- Synchronous flush.
- Overflow and underflow pulse flags.
- Selectable asynchronous or registered memory read.

Sits between bus bridges and DMA engines wherever a producer must be able to retract a partially written burst.

Parameters:
BW, 8, data width in bits
LGFLEN, 4, log2 of depth; FLEN = 2^LGFLEN entries
OPT_PACKET, 1, 1 = commit/abort active; 0 = every accepted write is committed immediately, i_commit/i_abort ignored
OPT_ASYNC_READ, 1, 1 = o_data read combinationally from memory; 0 = registered memory read plus bypass register, same external timing

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset_n  in  1  synchronous active-low reset
i_flush  in  1  synchronous clear of all contents and pointers
i_wr  in  1  write request
i_data  in  BW  write data
i_commit  in  1  make all pending (uncommitted) words, including this cycle's write, visible
i_abort  in  1  discard all pending words, including this cycle's write
o_full  out  1  total occupancy (committed + pending) == FLEN
o_pending  out  LGFLEN+1  uncommitted word count
o_overflow  out  1  one-cycle pulse: i_wr while o_full
i_afull_thresh  in  LGFLEN+1  almost-full threshold
o_afull  out  1  total occupancy >= i_afull_thresh
i_rd  in  1  read/pop request
o_data  out  BW  head-of-FIFO data, valid while !o_empty
o_empty  out  1  committed occupancy == 0
o_fill  out  LGFLEN+1  committed word count
i_aempty_thresh  in  LGFLEN+1  almost-empty threshold
o_aempty  out  1  committed occupancy <= i_aempty_thresh
o_underflow  out  1  one-cycle pulse: i_rd while o_empty

Behaviour:
- Pointers (LGFLEN+1 bits, modulo wrap, extra MSB distinguishes full from empty):
  - wr_addr: speculative write pointer.
  - cm_addr: committed pointer.
  - rd_addr: read pointer.
  - Invariant: rd_addr <= cm_addr <= wr_addr (modulo).
- o_fill = cm_addr - rd_addr. o_pending = wr_addr - cm_addr. Total = o_fill + o_pending, never > FLEN.
- Accept rules: w_wr = i_wr && !o_full; w_rd = i_rd && !o_empty. Write on full is dropped; read on empty is ignored.
- Memory write: mem[wr_addr[LGFLEN-1:0]] <= i_data on w_wr.
- Next-state priority, highest first:
  - Reset: all pointers 0.
  - Flush: all pointers 0, same-cycle write and read dropped.
  - Abort (OPT_PACKET): wr_addr <= cm_addr; same-cycle w_wr discarded; the read still proceeds. Abort beats commit when both are asserted.
  - Commit (OPT_PACKET): cm_addr <= wr_addr + w_wr.
  - Normal: wr_addr += w_wr; rd_addr += w_rd. With OPT_PACKET=0, cm_addr follows wr_addr every cycle.
- Commit with zero pending and no write: no effect.
- Flags: o_full, o_empty, o_fill, o_pending, o_afull, o_aempty are registered from next-state pointers, so they are consistent with the pointers in the same cycle.
  - Same-cycle w_wr + w_rd leaves total occupancy unchanged.
  - Committed fill changes by (committed words) - w_rd.
- Thresholds are sampled each cycle. A threshold change takes effect on the following edge.
- Latency: a committed word is visible (o_empty falls) on the cycle after the commit edge. Uncommitted words are never visible.
- Read timing: o_data presents mem[rd_addr] whenever !o_empty. The next word appears the cycle after w_rd.
  - With OPT_ASYNC_READ=0: prefetch mem[rd_addr+1] on w_rd.
  - A bypass register covers a commit into an empty FIFO, or into fill==1 with a same-cycle read.
  - Externally identical to OPT_ASYNC_READ=1.
- o_overflow / o_underflow are registered one-cycle pulses, the cycle after the offending request.
- Reset values: o_empty=1, o_full=0, o_fill=0, o_pending=0, o_afull=0, o_aempty=1, o_overflow=0, o_underflow=0. o_data is don't-care while empty.
- Reset or flush mid-packet discards pending and committed data. No partial state survives.

Test Plan:
1. LGFLEN=4, OPT_PACKET=0: write 0x01..0x10 (16 words) -> o_full=1 after 16th; 17th write (0xAA) gives o_overflow pulse; read 16 -> data 0x01..0x10 in order, o_empty=1, one read on empty gives o_underflow pulse.
2. OPT_PACKET=1: write 0x11,0x22,0x33, no commit -> o_empty=1, o_pending=3; i_commit alone -> next cycle o_fill=3, o_pending=0, o_data=0x11.
3. Write 0x44,0x55, then write 0x66 with i_abort -> o_pending=0, o_fill unchanged. Next packet 0x77 with i_commit in the same cycle -> read yields 0x77 after prior data; 0x44/0x55/0x66 are never seen.
4. Thresholds afull=12, aempty=2: fill to 12 -> o_afull=1 at 12, 0 at 11; drain to 2 -> o_aempty=1; simultaneous read+write at fill 12 -> o_afull stays 1.
5. Wrap-around: 40 cycles of simultaneous write/read with incrementing data at fill 5 -> data order intact, o_fill constant 5, pointers wrap. Run for both OPT_ASYNC_READ settings.
6. i_flush at fill 9 with pending 3 and a same-cycle write -> next cycle all counts 0, o_empty=1; then i_reset_n=0 mid-packet -> reset values above.
